// File: rtl/sccb_if.sv
// sccb_if: request/response handshake plus split SIOD pad (out/oe/in) for the SCCB master.
interface sccb_if;
  logic       start;
  logic       rw;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       sioc;
  logic       siod_out;
  logic       siod_oe;
  logic       siod_in;
  modport master (
    input  start, rw, reg_addr, wr_data, siod_in,
    output busy, done, rd_data, sioc, siod_out, siod_oe
  );
  modport slave (
    output start, rw, reg_addr, wr_data, siod_in,
    input  busy, done, rd_data, sioc, siod_out, siod_oe
  );
endinterface

// File: rtl/sccb_master.sv
// sccb_master: SCCB transaction engine with 3-phase writes and 2-phase-write + 2-phase-read register reads.
module sccb_master #(
  parameter int         QUARTER_CYCLES = 125,
  parameter logic [7:0] SLAVE_ID       = 8'h42,
  parameter int         GAP_CYCLES     = 1000
) (
  input logic    clk50m,
  input logic    rst,
  sccb_if.master bus
);
  localparam int CMAX = QUARTER_CYCLES > GAP_CYCLES ? QUARTER_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX);
  typedef enum logic [2:0] {IDLE, START, BITS, STOP, GAP, DONE} state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    q, q_n;
  logic [3:0]    bpos, bpos_n;
  logic [1:0]    byte_i, byte_i_n;
  logic          ph2, ph2_n;
  logic          rd_op;
  logic [7:0]    addr_r, data_r, shift, tx_byte;
  logic          q_end, gap_end, last_bit, rx, ack, bit_oe, bit_out;
  logic          sioc_n, out_n, oe_n;
  assign q_end    = cnt == CW'(QUARTER_CYCLES - 1);
  assign gap_end  = cnt == CW'(GAP_CYCLES - 1);
  assign last_bit = bpos == 4'd8 && byte_i == (rd_op ? 2'd1 : 2'd2);
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    q_n      = q;
    bpos_n   = bpos;
    byte_i_n = byte_i;
    ph2_n    = ph2;
    case (state)
      IDLE: if (bus.start) begin
        state_n = START;
        ph2_n   = 1'b0;
      end
      START, BITS, STOP: begin
        cnt_n = q_end ? '0 : cnt + 1'b1;
        q_n   = q_end ? q + 2'd1 : q;
        if (q_end && q == 2'd3) begin
          if (state == START) begin
            state_n  = BITS;
            bpos_n   = '0;
            byte_i_n = '0;
          end else if (state == BITS) begin
            state_n  = last_bit ? STOP : BITS;
            bpos_n   = bpos == 4'd8 ? 4'd0 : bpos + 4'd1;
            byte_i_n = byte_i + {1'b0, bpos == 4'd8};
          end else
            state_n = GAP;
        end
      end
      GAP: begin
        cnt_n = gap_end ? '0 : cnt + 1'b1;
        if (gap_end) begin
          state_n = rd_op && !ph2 ? START : DONE;
          ph2_n   = rd_op;
        end
      end
      default: state_n = IDLE;
    endcase
    // pad values are decoded from the next state so they register together with it
    tx_byte = byte_i_n == 2'd0 ? SLAVE_ID | {7'd0, ph2_n} : byte_i_n == 2'd1 ? addr_r : data_r;
    rx      = ph2_n && byte_i_n == 2'd1;
    ack     = bpos_n == 4'd8;
    bit_oe  = ack ? rx : !rx;
    bit_out = ack | tx_byte[3'd7 - bpos_n[2:0]];
    sioc_n  = state_n == START ? q_n != 2'd3 :
              state_n == BITS  ? q_n == 2'd1 || q_n == 2'd2 :
              state_n == STOP  ? q_n != 2'd0 : 1'b1;
    out_n   = state_n == START ? q_n == 2'd0 :
              state_n == BITS  ? bit_out :
              state_n == STOP  ? q_n[1] : 1'b1;
    oe_n    = state_n == START ? 1'b1 :
              state_n == BITS  ? bit_oe :
              state_n == STOP  ? q_n != 2'd3 : 1'b0;
  end
  always_ff @(posedge clk50m) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      q            <= '0;
      bpos         <= '0;
      byte_i       <= '0;
      ph2          <= 1'b0;
      rd_op        <= 1'b0;
      addr_r       <= '0;
      data_r       <= '0;
      shift        <= '0;
      bus.rd_data  <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.sioc     <= 1'b1;
      bus.siod_out <= 1'b1;
      bus.siod_oe  <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      q            <= q_n;
      bpos         <= bpos_n;
      byte_i       <= byte_i_n;
      ph2          <= ph2_n;
      bus.busy     <= state_n != IDLE;
      bus.done     <= state_n == DONE;
      bus.sioc     <= sioc_n;
      bus.siod_out <= out_n;
      bus.siod_oe  <= oe_n;
      if (state == IDLE && bus.start) begin
        rd_op  <= bus.rw;
        addr_r <= bus.reg_addr;
        data_r <= bus.wr_data;
      end
      if (state == BITS && ph2 && byte_i == 2'd1 && bpos != 4'd8 && q == 2'd1 && q_end)
        shift <= {shift[6:0], bus.siod_in};
      if (state_n == DONE && rd_op)
        bus.rd_data <= shift;
    end
  end
endmodule
